stopwatch_timebase_core: RTL

Timekeeping core of the stopwatch. It divides the system clock down to a 100 Hz tick and counts minutes, seconds and centiseconds in binary. It also runs the start/stop/lap/clear control FSM and drives the binary min/sec/centis buses consumed by the downstream BCD split stage. The buses show either the live count or a frozen lap snapshot.

---
 rtl/stopwatch_timebase_core.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/stopwatch_timebase_core.sv
// Stopwatch timebase: divides clk down to a centisecond tick, keeps a binary
// min:sec.centis count, runs the IDLE/RUN/PAUSE control FSM and presents
// either the live count or a frozen lap snapshot on registered output buses.
module stopwatch_timebase_core #(
    parameter int DIV     = 500000,
    parameter int MAX_MIN = 99
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_ss,
    input  logic       btn_lr,
    output logic [6:0] min,
    output logic [5:0] sec,
    output logic [6:0] centis,
    output logic       running,
    output logic       lap_hold,
    output logic       ovf
);

    localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
    localparam logic [6:0]    MIN_LAST   = 7'(MAX_MIN);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [6:0]    live_min_q, live_min_d;
    logic [5:0]    live_sec_q, live_sec_d;
    logic [6:0]    live_cs_q, live_cs_d;
    logic [6:0]    lap_min_q, lap_min_d;
    logic [5:0]    lap_sec_q, lap_sec_d;
    logic [6:0]    lap_cs_q, lap_cs_d;
    logic          lap_hold_q, lap_hold_d;
    logic          ovf_q, ovf_d;
    logic [6:0]    min_q, min_d;
    logic [5:0]    sec_q, sec_d;
    logic [6:0]    centis_q, centis_d;
    logic          running_q, running_d;
    logic          tick;
    logic          at_max;

    // Next-state: prescaler, carry chain, overflow, FSM and lap latch.
    always_comb begin
        state_d    = state_q;
        presc_d    = presc_q;
        live_min_d = live_min_q;
        live_sec_d = live_sec_q;
        live_cs_d  = live_cs_q;
        lap_min_d  = lap_min_q;
        lap_sec_d  = lap_sec_q;
        lap_cs_d   = lap_cs_q;
        lap_hold_d = lap_hold_q;
        ovf_d      = ovf_q;

        tick   = (state_q == RUN) && (presc_q == PRESC_LAST);
        at_max = (live_min_q == MIN_LAST) && (live_sec_q == 6'd59) && (live_cs_q == 7'd99);

        // Prescaler only moves in RUN, so a pause keeps the partial centisecond.
        if (state_q == RUN) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
        end

        if (tick) begin
            if (at_max) begin
                // Saturate: counters stay put, the watch drops into PAUSE.
                ovf_d   = 1'b1;
                state_d = PAUSE;
            end else if (live_cs_q != 7'd99) begin
                live_cs_d = live_cs_q + 7'd1;
            end else begin
                live_cs_d = 7'd0;
                if (live_sec_q != 6'd59) begin
                    live_sec_d = live_sec_q + 6'd1;
                end else begin
                    // at_max excludes min==MAX_MIN here, so this stays in range.
                    live_sec_d = 6'd0;
                    live_min_d = live_min_q + 7'd1;
                end
            end
        end

        // btn_ss always wins over a same-cycle btn_lr.
        case (state_q)
            IDLE: begin
                if (btn_ss) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (btn_ss) begin
                    state_d = PAUSE;
                end else if (btn_lr) begin
                    if (lap_hold_q) begin
                        lap_hold_d = 1'b0;
                    end else begin
                        // Snapshot the pre-tick value seen at this edge.
                        lap_hold_d = 1'b1;
                        lap_min_d  = live_min_q;
                        lap_sec_d  = live_sec_q;
                        lap_cs_d   = live_cs_q;
                    end
                end
            end
            PAUSE: begin
                if (btn_ss) begin
                    if (!ovf_q) begin
                        state_d = RUN;
                    end
                end else if (btn_lr) begin
                    state_d    = IDLE;
                    presc_d    = '0;
                    live_min_d = 7'd0;
                    live_sec_d = 6'd0;
                    live_cs_d  = 7'd0;
                    lap_min_d  = 7'd0;
                    lap_sec_d  = 6'd0;
                    lap_cs_d   = 7'd0;
                    lap_hold_d = 1'b0;
                    ovf_d      = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Output registers follow the next state so they track it edge for edge.
        min_d     = lap_hold_d ? lap_min_d : live_min_d;
        sec_d     = lap_hold_d ? lap_sec_d : live_sec_d;
        centis_d  = lap_hold_d ? lap_cs_d  : live_cs_d;
        running_d = (state_d == RUN);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            presc_q    <= '0;
            live_min_q <= 7'd0;
            live_sec_q <= 6'd0;
            live_cs_q  <= 7'd0;
            lap_min_q  <= 7'd0;
            lap_sec_q  <= 6'd0;
            lap_cs_q   <= 7'd0;
            lap_hold_q <= 1'b0;
            ovf_q      <= 1'b0;
            min_q      <= 7'd0;
            sec_q      <= 6'd0;
            centis_q   <= 7'd0;
            running_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            live_min_q <= live_min_d;
            live_sec_q <= live_sec_d;
            live_cs_q  <= live_cs_d;
            lap_min_q  <= lap_min_d;
            lap_sec_q  <= lap_sec_d;
            lap_cs_q   <= lap_cs_d;
            lap_hold_q <= lap_hold_d;
            ovf_q      <= ovf_d;
            min_q      <= min_d;
            sec_q      <= sec_d;
            centis_q   <= centis_d;
            running_q  <= running_d;
        end
    end

    assign min      = min_q;
    assign sec      = sec_q;
    assign centis   = centis_q;
    assign running  = running_q;
    assign lap_hold = lap_hold_q;
    assign ovf      = ovf_q;

endmodule
